// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and widths.
package fetch_pkg;

  localparam int INSTR_W      = 32;
  localparam int DEFAULT_ALEN = 6;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {address, instruction} pairs for the decoder.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int ALEN  = DEFAULT_ALEN,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [ALEN-1:0]    i_pushAddr,
  input  logic [INSTR_W-1:0] i_pushData,
  output logic [ALEN-1:0]    o_headAddr,
  output logic [INSTR_W-1:0] o_headData,
  output logic               o_full,
  output logic               o_empty,
  output logic [CW-1:0]      o_count
);

  logic [ALEN-1:0]    r_addrMem [DEPTH];
  logic [INSTR_W-1:0] r_dataMem [DEPTH];
  logic [PW-1:0]      r_wrPtr;
  logic [PW-1:0]      r_rdPtr;
  logic [CW-1:0]      r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_headAddr = r_addrMem[r_rdPtr];
  assign o_headData = r_dataMem[r_rdPtr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_doPush = i_push && !i_flush && (!o_full || i_pop);
  assign w_doPop  = i_pop && !i_flush && !o_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addrMem[i] <= '0;
        r_dataMem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_addrMem[r_wrPtr] <= i_pushAddr;
        r_dataMem[r_wrPtr] <= i_pushData;
        r_wrPtr            <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one-cycle-latency memory reads from the PC and
// buffers the returned words for the decoder.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ALEN  = DEFAULT_ALEN,
  parameter int DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ALEN-1:0]    pc_addr,
  output logic               pc_incr,
  output logic               imem_en,
  output logic [ALEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               halt,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr,
  output logic [ALEN-1:0]    instr_addr,
  output logic               instr_valid,
  input  logic               dec_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  fetchState_t     r_state;
  fetchState_t     w_nextState;
  logic            r_inflight;
  logic [ALEN-1:0] r_issueAddr;
  logic            w_issue;
  logic            w_pop;
  logic            w_push;
  logic            w_room;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_used;
  logic [CW:0]     w_need;

  fetch_fifo #(
    .ALEN  (ALEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (flush),
    .i_pushAddr (r_issueAddr),
    .i_pushData (imem_rdata),
    .o_headAddr (instr_addr),
    .o_headData (instr),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  assign instr_valid = !w_empty;
  assign w_pop       = instr_valid && dec_ready;
  assign w_push      = r_inflight && !w_full;

  // Credit the head leaving this cycle so the stream sustains one word per cycle.
  assign w_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_need = w_used - {{CW{1'b0}}, w_pop};
  assign w_room = (w_need < (CW+1)'(DEPTH));

  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    case (r_state)
      WAIT:    w_nextState = RUN;
      RUN: begin
        if (halt) begin
          w_nextState = HALTED;
        end else if (!flush && w_room) begin
          w_issue = 1'b1;
        end
      end
      HALTED:  if (!halt) w_nextState = RUN;
      default: w_nextState = WAIT;
    endcase
  end

  assign imem_en   = w_issue;
  assign pc_incr   = w_issue;
  assign imem_addr = w_issue ? pc_addr : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= WAIT;
      r_inflight  <= 1'b0;
      r_issueAddr <= '0;
    end else begin
      r_state    <= w_nextState;
      r_inflight <= w_issue && !flush;
      if (w_issue) begin
        r_issueAddr <= pc_addr;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: models PC and 1-cycle memory, compares every delivered word.
module tb_instr_fetch;

  localparam int ALEN  = 6;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [ALEN-1:0] addr;
    logic [31:0]     data;
  } expEntry_t;

  logic            clock = 1'b0;
  logic            reset;
  logic [ALEN-1:0] pcAddr;
  logic            pc_incr;
  logic            imem_en;
  logic [ALEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            halt;
  logic            flush;
  logic [31:0]     instr;
  logic [ALEN-1:0] instr_addr;
  logic            instr_valid;
  logic            dec_ready;

  int              testsRun    = 0;
  int              testsFailed = 0;
  int              issueCount  = 0;
  expEntry_t       sbQueue[$];
  logic            issueSeen = 1'b0;
  logic [ALEN-1:0] issueAddrSeen = '0;
  logic            pcLoadReq;
  logic [ALEN-1:0] pcLoadVal;
  logic            holdValid = 1'b0;
  logic [31:0]     holdInstr;
  logic [ALEN-1:0] holdAddr;
  logic            seqValid = 1'b0;
  logic [ALEN-1:0] seqNext;

  always #5 clock = ~clock;

  instr_fetch #(
    .ALEN  (ALEN),
    .DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_addr     (pcAddr),
    .pc_incr     (pc_incr),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .halt        (halt),
    .flush       (flush),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready)
  );

  function automatic logic [31:0] memWord(input logic [ALEN-1:0] a);
    return 32'h100 + 32'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hlt, input logic fl, input logic rdy);
    @(posedge clock);
    #1;
    reset     = rst;
    halt      = hlt;
    flush     = fl;
    dec_ready = rdy;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 64'(instr_valid), 64'd1);
  endtask

  // Program counter and instruction memory environment, driven by what the monitor saw.
  always @(posedge clock) begin
    if (pcLoadReq) pcAddr <= pcLoadVal;
    else if (issueSeen) pcAddr <= pcAddr + ALEN'(1);
    imem_rdata <= issueSeen ? memWord(issueAddrSeen) : 32'hDEAD_BEEF;
  end

  // Monitor: records issues into the scoreboard and checks every handshake transfer.
  always @(negedge clock) begin
    expEntry_t e;
    issueSeen     = imem_en;
    issueAddrSeen = imem_addr;
    if (reset) begin
      sbQueue.delete();
      seqValid  = 1'b0;
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        checkOutput("hold_instr", 64'(instr), 64'(holdInstr));
        checkOutput("hold_addr", 64'(instr_addr), 64'(holdAddr));
        checkOutput("hold_valid", 64'(instr_valid), 64'd1);
      end
      if (halt || flush) checkOutput("no_issue", 64'(imem_en), 64'd0);
      checkOutput("incr_eq_en", 64'(pc_incr), 64'(imem_en));
      if (imem_en) begin
        checkOutput("imem_addr", 64'(imem_addr), 64'(pcAddr));
        issueCount++;
      end
      if (instr_valid && dec_ready && !flush) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sb_unexpected", 64'(sbQueue.size()), 64'd1);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("sb_instr", 64'(instr), 64'(e.data));
          checkOutput("sb_addr", 64'(instr_addr), 64'(e.addr));
        end
        if (seqValid) checkOutput("seq_addr", 64'(instr_addr), 64'(seqNext));
        seqNext  = instr_addr + ALEN'(1);
        seqValid = 1'b1;
      end
      holdValid = instr_valid && !dec_ready && !flush;
      holdInstr = instr;
      holdAddr  = instr_addr;
      if (flush) begin
        sbQueue.delete();
        seqValid = 1'b0;
      end
      if (imem_en) sbQueue.push_back({pcAddr, memWord(pcAddr)});
    end
  end

  task automatic runFlush(input logic rdy);
    logic [ALEN-1:0] resumeAddr;
    applyStimulus(1'b0, 1'b0, 1'b0, rdy);
    repeat (4) @(negedge clock);
    checkOutput("pre_flush_valid", 64'(instr_valid), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, rdy);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("flush_empty", 64'(instr_valid), 64'd0);
    resumeAddr = pcAddr;
    checkOutput("resume_issue", 64'(imem_en), 64'd1);
    checkOutput("resume_addr", 64'(imem_addr), 64'(resumeAddr));
    waitValid("flush_timeout");
    checkOutput("flush_next_addr", 64'(instr_addr), 64'(resumeAddr));
    checkOutput("flush_next_instr", 64'(instr), 64'(memWord(resumeAddr)));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int              base;
    logic [ALEN-1:0] haltPc;
    logic [ALEN-1:0] expA;

    reset     = 1'b1;
    halt      = 1'b0;
    flush     = 1'b0;
    dec_ready = 1'b1;
    pcLoadReq = 1'b1;
    pcLoadVal = '0;
    repeat (3) @(posedge clock);

    // Reset values
    @(negedge clock);
    checkOutput("rst_valid", 64'(instr_valid), 64'd0);
    checkOutput("rst_pc_incr", 64'(pc_incr), 64'd0);
    checkOutput("rst_imem_en", 64'(imem_en), 64'd0);
    checkOutput("rst_imem_addr", 64'(imem_addr), 64'd0);
    checkOutput("rst_instr", 64'(instr), 64'd0);
    checkOutput("rst_instr_addr", 64'(instr_addr), 64'd0);

    // Streaming from address 0 with the decoder always ready
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pcLoadReq = 1'b0;
    @(negedge clock);
    checkOutput("wait_no_issue", 64'(imem_en), 64'd0);
    @(negedge clock);
    checkOutput("first_issue", 64'(imem_en), 64'd1);
    checkOutput("first_issue_addr", 64'(imem_addr), 64'd0);
    @(negedge clock);
    checkOutput("no_bypass", 64'(instr_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("stream_valid", 64'(instr_valid), 64'd1);
      checkOutput("stream_instr", 64'(instr), 64'(32'h100 + k));
      checkOutput("stream_addr", 64'(instr_addr), 64'(k));
    end

    // Decoder stalled from reset: buffer fills, then releases without a gap
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    pcLoadReq = 1'b1;
    pcLoadVal = '0;
    repeat (2) @(posedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pcLoadReq = 1'b0;
    base = issueCount;
    repeat (10) @(negedge clock);
    checkOutput("stall_pulses", 64'(issueCount - base), 64'd2);
    checkOutput("stall_valid", 64'(instr_valid), 64'd1);
    checkOutput("stall_instr", 64'(instr), 64'h100);
    checkOutput("stall_addr", 64'(instr_addr), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    @(negedge clock);
    checkOutput("release_valid", 64'(instr_valid), 64'd1);
    checkOutput("release_instr", 64'(instr), 64'h101);
    checkOutput("release_addr", 64'(instr_addr), 64'd1);

    // Flush while streaming, then while the buffer is full
    runFlush(1'b1);
    runFlush(1'b0);

    // Halt for five cycles during streaming
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clock);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    haltPc = pcAddr;
    repeat (4) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clock);
      checkOutput("halt_no_issue", 64'(imem_en), 64'd0);
    end
    checkOutput("halt_pc_hold", 64'(pcAddr), 64'(haltPc));
    checkOutput("halt_drained", 64'(instr_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    waitValid("halt_timeout");
    checkOutput("halt_resume_addr", 64'(instr_addr), 64'(haltPc));
    checkOutput("halt_resume_instr", 64'(instr), 64'(memWord(haltPc)));

    // Address wrap from 60 through 63 to 0 and 1
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    pcLoadReq = 1'b1;
    pcLoadVal = ALEN'(60);
    repeat (2) @(posedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pcLoadReq = 1'b0;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      expA = ALEN'(60 + k);
      checkOutput("wrap_valid", 64'(instr_valid), 64'd1);
      checkOutput("wrap_addr", 64'(instr_addr), 64'(expA));
      checkOutput("wrap_instr", 64'(instr), 64'(memWord(expA)));
    end

    // Reset with a read in flight
    @(negedge clock);
    checkOutput("inflight_setup", 64'(imem_en), 64'd1);
    @(posedge clock);
    #1;
    reset     = 1'b1;
    pcLoadReq = 1'b1;
    pcLoadVal = ALEN'(10);
    #1;
    checkOutput("mid_rst_valid", 64'(instr_valid), 64'd0);
    checkOutput("mid_rst_imem_en", 64'(imem_en), 64'd0);
    checkOutput("mid_rst_pc_incr", 64'(pc_incr), 64'd0);
    checkOutput("mid_rst_imem_addr", 64'(imem_addr), 64'd0);
    checkOutput("mid_rst_instr", 64'(instr), 64'd0);
    checkOutput("mid_rst_instr_addr", 64'(instr_addr), 64'd0);
    repeat (2) @(posedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pcLoadReq = 1'b0;
    @(negedge clock);
    waitValid("post_rst_timeout");
    checkOutput("post_rst_addr", 64'(instr_addr), 64'd10);
    checkOutput("post_rst_instr", 64'(instr), 64'h10A);
    repeat (4) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ALEN, default 6, giving instruction word-address width (must match program counter width).
REQ-002 SHALL have parameter DEPTH, default 2, giving the number of instruction buffer entries (power of two, >= 2).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 pc_addr  input  ALEN  current word address from program counter.
REQ-006 pc_incr  output  1  one-cycle pulse commanding program counter to advance by 1.
REQ-007 imem_en  output  1  instruction memory read enable.
REQ-008 imem_addr  output  ALEN  instruction memory read address.
REQ-009 imem_rdata  input  32  read data, valid exactly 1 cycle after imem_en.
REQ-010 halt  input  1  level; while high, no new reads issued.
REQ-011 flush  input  1  one-cycle pulse; discard buffered and in-flight instructions.
REQ-012 instr  output  32  instruction at buffer head.
REQ-013 instr_addr  output  ALEN  word address of instr.
REQ-014 instr_valid  output  1  buffer head valid.
REQ-015 dec_ready  input  1  downstream decoder accepts head.

Function
REQ-016 SHALL implement FSM states WAIT, RUN, HALTED; WAIT after reset, RUN next cycle unconditionally.
REQ-017 RUN->HALTED when halt=1; HALTED->RUN when halt=0; no issue in WAIT or HALTED.
REQ-018 Issue condition: state RUN, halt=0, flush=0, (count + inflight) < DEPTH, with count = buffered entries, inflight = reads awaiting data (0 or 1).
REQ-019 On issue: imem_en=1, imem_addr=pc_addr, pc_incr=1 in the same cycle, combinationally; otherwise all three driven 0.
REQ-020 Back-to-back issue SHALL be possible every cycle while the condition holds (sustained throughput 1 instr/cycle with dec_ready=1).
REQ-021 Data returned 1 cycle after issue SHALL be written to buffer tail with the issued address.
REQ-022 Handshake: transfer when instr_valid=1 and dec_ready=1; head pops at that edge; instr/instr_addr stable while instr_valid=1 and dec_ready=0.
REQ-023 Buffer order SHALL be FIFO; simultaneous push and pop leaves count unchanged.
REQ-024 Full-buffer check includes in-flight read, so an arriving response never overflows.
REQ-025 Empty buffer: instr_valid=0; no bypass from imem_rdata to instr (1 cycle issue-to-visible minimum 2 cycles).
REQ-026 flush: count and inflight cleared at the edge, response arriving the next cycle discarded, no issue in flush cycle; flush has priority over push, pop and issue.
REQ-027 Address wrap: pc_addr (2^ALEN - 1) followed by 0 SHALL be handled as ordinary addresses; no special action.
REQ-028 halt asserted with read in flight: response still captured; halt does not clear buffer.

Reset
REQ-029 Reset SHALL force state=WAIT, count=0, inflight=0, buffer pointers=0, instr_valid=0, pc_incr=0, imem_en=0, imem_addr=0, instr=0, instr_addr=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight read; first issue occurs second rising edge after reset deassertion.

Structure
REQ-031 Shared package fetch_pkg SHALL hold state enum type, instruction width constant (32), default ALEN.
REQ-032 Buffer SHALL be a sub-module fetch_fifo (DEPTH entries of {ALEN addr, 32 instr}, push/pop/flush, full/empty/count).
REQ-033 All state in always_ff on posedge clock or posedge reset; issue logic combinational.

Verification
REQ-034 Reset, pc starts 0, mem[n]=n+0x100, dec_ready=1 -> instr 0x100,0x101,0x102 with instr_addr 0,1,2 on consecutive cycles from cycle 3.
REQ-035 dec_ready=0 from start -> exactly 2 pc_incr pulses, instr_valid=1 holding 0x100/addr 0; release -> 0x101 follows with no gap.
REQ-036 flush while 2 entries buffered and 1 in flight -> instr_valid=0 next cycle, stale data never presented, next instr equals mem[pc_addr at resume].
REQ-037 halt=1 for 5 cycles during streaming -> no imem_en during halt, in-flight instr delivered, stream resumes at next address without skip or duplicate.
REQ-038 pc_addr reaching 63 (ALEN=6) -> instr_addr sequence 62,63,0,1.
REQ-039 reset asserted with read in flight -> all outputs 0 immediately, no instr from that read ever presented.
